// File: rtl/wave_bank_writer.sv
// wave_bank_writer: turns interpolator DATA_READY strobes into banked wave-RAM writes,
// with decimation, loop/one-shot filling and bank-ownership handshaking with the reader.
module wave_bank_writer #(
    parameter int ADDR_W    = 8,
    parameter int BANK_W    = 4,
    parameter int NUM_BANKS = 16,
    parameter int DECIM_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               DATA_READY,
    input  logic               loop_mode,
    input  logic [DECIM_W-1:0] decim,
    input  logic               bank_release,
    output logic               WE,
    output logic [ADDR_W-1:0]  WADDR,
    output logic [BANK_W-1:0]  WBANK,
    output logic               bank_done,
    output logic [BANK_W-1:0]  done_bank,
    output logic               overflow,
    output logic               busy,
    output logic               done
);
    localparam int FW = BANK_W + 1;
    localparam logic [ADDR_W-1:0] PTR_MAX   = '1;
    localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(NUM_BANKS - 1);
    localparam logic [FW-1:0]     FULL      = FW'(NUM_BANKS);

    typedef enum logic [1:0] {IDLE, WRITE, STALL, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d, waddr_q, waddr_d;
    logic [BANK_W-1:0]   bank_q, bank_d, wbank_q, wbank_d, done_bank_q, done_bank_d;
    logic [DECIM_W-1:0]  dcnt_q, dcnt_d;
    logic [FW-1:0]       filled_q, filled_d;
    logic                we_q, we_d, bank_done_q, bank_done_d, overflow_q, overflow_d;
    logic                rel;

    // a release with nothing filled is meaningless and is dropped
    assign rel = bank_release && filled_q != '0;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        bank_d      = bank_q;
        dcnt_d      = dcnt_q;
        filled_d    = filled_q;
        we_d        = 1'b0;
        bank_done_d = 1'b0;
        waddr_d     = waddr_q;
        wbank_d     = wbank_q;
        done_bank_d = done_bank_q;
        overflow_d  = overflow_q;
        if (!enable) begin
            state_d  = IDLE;
            ptr_d    = '0;
            bank_d   = '0;
            dcnt_d   = '0;
            filled_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = WRITE;
                    overflow_d = 1'b0;
                end
                WRITE: begin
                    filled_d = filled_q - FW'(rel);
                    if (DATA_READY) begin
                        // dcnt beyond a freshly lowered decim counts as a match
                        if (dcnt_q < decim) begin
                            dcnt_d = dcnt_q + 1'b1;
                        end else begin
                            dcnt_d  = '0;
                            we_d    = 1'b1;
                            waddr_d = ptr_q;
                            wbank_d = bank_q;
                            ptr_d   = ptr_q + 1'b1;
                            if (ptr_q == PTR_MAX) begin
                                bank_done_d = 1'b1;
                                done_bank_d = bank_q;
                                filled_d    = filled_q - FW'(rel) + 1'b1;
                                bank_d      = (bank_q == BANK_LAST) ? '0 : bank_q + 1'b1;
                                if (filled_d == FULL) state_d = STALL;
                                // one-shot completion outranks a full-bank stall
                                if (bank_q == BANK_LAST && !loop_mode) begin
                                    state_d = DONE;
                                    bank_d  = bank_q;
                                end
                            end
                        end
                    end
                end
                STALL: begin
                    if (DATA_READY) overflow_d = 1'b1;
                    if (rel) begin
                        filled_d = filled_q - 1'b1;
                        state_d  = WRITE;
                    end
                end
                DONE: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            bank_q      <= '0;
            dcnt_q      <= '0;
            filled_q    <= '0;
            we_q        <= 1'b0;
            bank_done_q <= 1'b0;
            waddr_q     <= '0;
            wbank_q     <= '0;
            done_bank_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            bank_q      <= bank_d;
            dcnt_q      <= dcnt_d;
            filled_q    <= filled_d;
            we_q        <= we_d;
            bank_done_q <= bank_done_d;
            waddr_q     <= waddr_d;
            wbank_q     <= wbank_d;
            done_bank_q <= done_bank_d;
            overflow_q  <= overflow_d;
        end
    end

    assign WE        = we_q;
    assign WADDR     = waddr_q;
    assign WBANK     = wbank_q;
    assign bank_done = bank_done_q;
    assign done_bank = done_bank_q;
    assign overflow  = overflow_q;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
endmodule

// File: tb/tb_wave_bank_writer.sv
// tb_wave_bank_writer: directed scoreboard bench over three parameterisations of wave_bank_writer.
module tb_wave_bank_writer;
    typedef struct packed {
        int         cyc;
        logic       bd;
        logic [3:0] bank;
        logic [7:0] addr;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1;
    logic en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
    logic dr = 1'b0, loop_mode = 1'b1, bank_release = 1'b0;
    logic [3:0] decim = '0;
    int cyc = 0, checks = 0, errors = 0;
    exp_t qa[$], qb[$], qc[$];
    exp_t ea, eb, ec;

    logic we_a, bd_a, ov_a, busy_a, done_a;
    logic [7:0] waddr_a;
    logic [3:0] wbank_a, dbank_a;
    logic we_b, bd_b, ov_b, busy_b, done_b;
    logic [7:0] waddr_b;
    logic [3:0] wbank_b, dbank_b;
    logic we_c, bd_c, ov_c, busy_c, done_c;
    logic [3:0] waddr_c;
    logic [3:0] wbank_c, dbank_c;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wave_bank_writer dut_a (
        .clk(clk), .rst(rst), .enable(en_a), .DATA_READY(dr), .loop_mode(loop_mode),
        .decim(decim), .bank_release(bank_release), .WE(we_a), .WADDR(waddr_a),
        .WBANK(wbank_a), .bank_done(bd_a), .done_bank(dbank_a), .overflow(ov_a),
        .busy(busy_a), .done(done_a));

    wave_bank_writer #(.ADDR_W(8), .NUM_BANKS(2)) dut_b (
        .clk(clk), .rst(rst), .enable(en_b), .DATA_READY(dr), .loop_mode(loop_mode),
        .decim(decim), .bank_release(bank_release), .WE(we_b), .WADDR(waddr_b),
        .WBANK(wbank_b), .bank_done(bd_b), .done_bank(dbank_b), .overflow(ov_b),
        .busy(busy_b), .done(done_b));

    wave_bank_writer #(.ADDR_W(4), .NUM_BANKS(4)) dut_c (
        .clk(clk), .rst(rst), .enable(en_c), .DATA_READY(dr), .loop_mode(loop_mode),
        .decim(decim), .bank_release(bank_release), .WE(we_c), .WADDR(waddr_c),
        .WBANK(wbank_c), .bank_done(bd_c), .done_bank(dbank_c), .overflow(ov_c),
        .busy(busy_c), .done(done_c));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: write output with no expected entry (cycle %0d)", nm, cyc);
    endtask

    task automatic cmp(input string nm, input exp_t e, input logic bd, input logic [3:0] bk,
                       input logic [7:0] ad, input logic [3:0] dbk);
        chk({nm, "_we_cycle"}, cyc, e.cyc);
        chk({nm, "_wbank"}, {28'd0, bk}, {28'd0, e.bank});
        chk({nm, "_waddr"}, {24'd0, ad}, {24'd0, e.addr});
        chk({nm, "_bank_done"}, {31'd0, bd}, {31'd0, e.bd});
        if (e.bd) chk({nm, "_done_bank"}, {28'd0, dbk}, {28'd0, e.bank});
    endtask

    // monitors: every WE or bank_done pops one expected write
    always @(negedge clk) begin
        if (we_a || bd_a) begin
            if (qa.size() == 0) unexpected("a_we");
            else begin ea = qa.pop_front(); cmp("a", ea, bd_a, wbank_a, waddr_a, dbank_a); end
        end
        if (we_b || bd_b) begin
            if (qb.size() == 0) unexpected("b_we");
            else begin eb = qb.pop_front(); cmp("b", eb, bd_b, wbank_b, waddr_b, dbank_b); end
        end
        if (we_c || bd_c) begin
            if (qc.size() == 0) unexpected("c_we");
            else begin ec = qc.pop_front(); cmp("c", ec, bd_c, wbank_c, {4'd0, waddr_c}, dbank_c); end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // expected write lands one cycle after the strobe is sampled
    task automatic push(input int d, input logic bd, input int bk, input int ad);
        exp_t e;
        e.cyc  = cyc + 1;
        e.bd   = bd;
        e.bank = 4'(bk);
        e.addr = 8'(ad);
        if (d == 0) qa.push_back(e);
        else if (d == 1) qb.push_back(e);
        else qc.push_back(e);
    endtask

    task automatic pulse_dr(input int gap, input logic rel_after);
        dr = 1'b1;
        step();
        dr = 1'b0;
        bank_release = rel_after;
        step();
        bank_release = 1'b0;
        repeat (gap - 2) step();
    endtask

    task automatic drain(input string nm);
        repeat (4) step();
        chk({nm, "_pending_a"}, qa.size(), 0);
        chk({nm, "_pending_b"}, qb.size(), 0);
        chk({nm, "_pending_c"}, qc.size(), 0);
    endtask

    task automatic restart_a();
        en_a = 1'b0;
        repeat (2) step();
        en_a = 1'b1;
        step();
    endtask

    initial begin
        repeat (2) step();
        chk("rst_we_a", {31'd0, we_a}, 0);
        chk("rst_busy_a", {31'd0, busy_a}, 0);
        chk("rst_waddr_a", {24'd0, waddr_a}, 0);
        chk("rst_wbank_a", {28'd0, wbank_a}, 0);
        chk("rst_flags_a", {28'd0, bd_a, ov_a, done_a, busy_a}, 0);
        chk("rst_flags_b", {28'd0, we_b, ov_b, done_b, busy_b}, 0);
        chk("rst_flags_c", {28'd0, we_c, ov_c, done_c, busy_c}, 0);
        rst = 1'b0;

        // 1: loop fill across a bank boundary with reader releases
        loop_mode = 1'b1;
        decim = 4'd0;
        restart_a();
        chk("t1_busy", {31'd0, busy_a}, 1);
        for (int i = 0; i < 261; i++) begin
            push(0, i == 255, i / 256, i % 256);
            pulse_dr(6, i == 255);
        end
        drain("t1");
        chk("t1_last_waddr", {24'd0, waddr_a}, 4);
        chk("t1_last_wbank", {28'd0, wbank_a}, 1);
        chk("t1_overflow", {31'd0, ov_a}, 0);

        // 2: decimation by 4
        decim = 4'd3;
        restart_a();
        for (int i = 0; i < 40; i++) begin
            if (i % 4 == 3) push(0, 1'b0, 0, i / 4);
            pulse_dr(2, 1'b0);
        end
        drain("t2");
        decim = 4'd0;

        // 3: strobe held high for a full bank
        restart_a();
        dr = 1'b1;
        for (int i = 0; i < 256; i++) begin
            push(0, i == 255, 0, i);
            step();
        end
        dr = 1'b0;
        drain("t3");

        // 4: two banks, no releases, stall and overflow, then recovery
        en_a = 1'b0;
        en_b = 1'b1;
        step();
        for (int i = 0; i < 512; i++) begin
            push(1, i % 256 == 255, i / 256, i % 256);
            pulse_dr(2, 1'b0);
        end
        drain("t4");
        chk("t4_busy_stall", {31'd0, busy_b}, 1);
        chk("t4_no_ov_yet", {31'd0, ov_b}, 0);
        for (int i = 0; i < 3; i++) pulse_dr(2, 1'b0);
        chk("t4_overflow", {31'd0, ov_b}, 1);
        bank_release = 1'b1;
        step();
        bank_release = 1'b0;
        push(1, 1'b0, 0, 0);
        pulse_dr(2, 1'b0);
        drain("t4b");
        chk("t4_overflow_sticky", {31'd0, ov_b}, 1);
        en_b = 1'b0;

        // 5: one-shot fill of four 16-entry banks
        loop_mode = 1'b0;
        en_c = 1'b1;
        step();
        for (int i = 0; i < 64; i++) begin
            push(2, i % 16 == 15, i / 16, i % 16);
            pulse_dr(3, i % 16 == 15);
        end
        drain("t5");
        chk("t5_done", {31'd0, done_c}, 1);
        chk("t5_busy", {31'd0, busy_c}, 1);
        for (int i = 0; i < 3; i++) pulse_dr(3, 1'b0);
        drain("t5b");
        en_c = 1'b0;
        step();
        chk("t5_done_clear", {31'd0, done_c}, 0);
        chk("t5_busy_clear", {31'd0, busy_c}, 0);
        loop_mode = 1'b1;

        // 6: reset mid-fill with enable held
        restart_a();
        for (int i = 0; i < 100; i++) begin
            push(0, 1'b0, 0, i);
            pulse_dr(2, 1'b0);
        end
        drain("t6");
        chk("t6_pre_waddr", {24'd0, waddr_a}, 99);
        rst = 1'b1;
        step();
        chk("t6_rst_we", {31'd0, we_a}, 0);
        chk("t6_rst_waddr", {24'd0, waddr_a}, 0);
        chk("t6_rst_wbank", {28'd0, wbank_a}, 0);
        chk("t6_rst_flags", {28'd0, bd_a, ov_a, done_a, busy_a}, 0);
        rst = 1'b0;
        step();
        push(0, 1'b0, 0, 0);
        pulse_dr(2, 1'b0);
        drain("t6b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
